// File: rtl/change_payout_ctrl.sv
// change_payout_ctrl: turns a change amount in cents into a sequence of
// coin-dispense pulses, largest denomination first, with a fixed idle gap
// after every pulse. Whatever cannot be paid is reported as shortfall.
//
// Build option: define COIN_STOCK_EN to track a per-denomination coin stock
// (empty tubes are skipped and refill reloads them). Without it every
// denomination is treated as unlimited and refill is ignored.
//
// Denomination codes: 1=10c, 2=20c, 3=50c, 4=100c, 5=200c.
module change_payout_ctrl #(
  parameter int DISP_GAP   = 2,  // idle cycles after each coin pulse (0..15)
  parameter int STOCK_INIT = 8   // coins per denomination after reset/refill (0..255)
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [15:0] req_amount,
  output logic        coin_valid,
  output logic [2:0]  coin_code,
  output logic        busy,
  output logic        done,
  output logic [15:0] shortfall,
  input  logic        refill
);

  localparam int         NUM_DENOM  = 5;
  localparam logic [3:0] GAP_LOAD   = (DISP_GAP > 0) ? 4'(DISP_GAP - 1) : 4'd0;
  localparam logic [7:0] STOCK_LOAD = 8'(STOCK_INIT);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SELECT,
    S_EMIT,
    S_GAP,
    S_FINISH
  } state_t;

  state_t r_state;
  state_t w_state_next;

  logic [15:0] r_rem;
  logic [3:0]  r_gap_cnt;
  logic        r_coin_valid;
  logic [2:0]  r_coin_code;
  logic        r_done;
  logic [15:0] r_shortfall;

  logic [NUM_DENOM-1:0] w_has_stock;
  logic [NUM_DENOM-1:0] w_fits;
  logic                 w_sel_found;
  logic [2:0]           w_sel_code;
  logic                 w_accept;

  // Cent value of a denomination code; unused codes are worth nothing.
  function automatic logic [15:0] coin_value(input logic [2:0] code);
    logic [15:0] v;
    case (code)
      3'd1:    v = 16'd10;
      3'd2:    v = 16'd20;
      3'd3:    v = 16'd50;
      3'd4:    v = 16'd100;
      3'd5:    v = 16'd200;
      default: v = 16'd0;
    endcase
    return v;
  endfunction

  assign req_ready = (r_state == S_IDLE);
  assign busy      = (r_state != S_IDLE);
  assign w_accept  = req_valid && req_ready;

  assign coin_valid = r_coin_valid;
  assign coin_code  = r_coin_code;
  assign done       = r_done;
  assign shortfall  = r_shortfall;

`ifdef COIN_STOCK_EN
  logic [7:0] r_stock [NUM_DENOM];

  // Stock counters: refill overrides the decrement of a coin emitted on the
  // same edge, so a refill always leaves every tube exactly full.
  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_DENOM; i++) begin
      if (rst || refill) begin
        r_stock[i] <= STOCK_LOAD;
      end else if ((r_state == S_EMIT) && (r_coin_code == 3'(i + 1))) begin
        r_stock[i] <= r_stock[i] - 8'd1;
      end
    end
  end

  generate
    for (genvar gi = 0; gi < NUM_DENOM; gi++) begin : g_stock_flag
      assign w_has_stock[gi] = (r_stock[gi] != 8'd0);
    end
  endgenerate
`else
  // Unlimited stock: every denomination is always available.
  logic w_unused_refill;
  assign w_unused_refill = refill;
  assign w_has_stock     = '1;
`endif

  // A denomination is a candidate when it does not exceed the remaining
  // amount and its tube is not empty; this is what keeps rem from going
  // negative.
  generate
    for (genvar gi = 0; gi < NUM_DENOM; gi++) begin : g_fits
      assign w_fits[gi] = (coin_value(3'(gi + 1)) <= r_rem) && w_has_stock[gi];
    end
  endgenerate

  // Priority pick: higher codes overwrite lower ones, so the largest
  // candidate denomination wins.
  always_comb begin
    w_sel_found = |w_fits;
    w_sel_code  = 3'd0;
    for (int i = 0; i < NUM_DENOM; i++) begin
      if (w_fits[i]) begin
        w_sel_code = 3'(i + 1);
      end
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state logic: SELECT -> EMIT -> GAP loop per coin, FINISH once no
  // denomination can be paid any more.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          w_state_next = S_SELECT;
        end
      end
      S_SELECT: begin
        w_state_next = w_sel_found ? S_EMIT : S_FINISH;
      end
      S_EMIT: begin
        w_state_next = (DISP_GAP > 0) ? S_GAP : S_SELECT;
      end
      S_GAP: begin
        if (r_gap_cnt == 4'd0) begin
          w_state_next = S_SELECT;
        end
      end
      S_FINISH: begin
        w_state_next = S_IDLE;
      end
      default: begin
        w_state_next = S_IDLE;
      end
    endcase
  end

  // Datapath and registered outputs. The coin pulse and done pulse are
  // loaded on the edge leaving SELECT so that they are high exactly while
  // the FSM sits in EMIT or FINISH respectively.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rem        <= 16'd0;
      r_gap_cnt    <= 4'd0;
      r_coin_valid <= 1'b0;
      r_coin_code  <= 3'd0;
      r_done       <= 1'b0;
      r_shortfall  <= 16'd0;
    end else begin
      r_coin_valid <= 1'b0;
      r_coin_code  <= 3'd0;
      r_done       <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_rem       <= req_amount;
            r_shortfall <= 16'd0;
          end
        end
        S_SELECT: begin
          if (w_sel_found) begin
            r_coin_valid <= 1'b1;
            r_coin_code  <= w_sel_code;
          end else begin
            r_done      <= 1'b1;
            r_shortfall <= r_rem;
          end
        end
        S_EMIT: begin
          r_rem     <= r_rem - coin_value(r_coin_code);
          r_gap_cnt <= GAP_LOAD;
        end
        S_GAP: begin
          if (r_gap_cnt != 4'd0) begin
            r_gap_cnt <= r_gap_cnt - 4'd1;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule
